// File: rtl/mult32x32_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult32x32_arb_pkg
// Description : Shared types and widths for the multiplier arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package mult32x32_arb_pkg;

  localparam int OP_W   = 32;
  localparam int PROD_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mult32x32_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mult32x32_arbiter_if
// Description : Requester, response and multiplier-side bus of the arbiter.
//               slave = arbiter view, master = client/multiplier view.
// Revision    : 1.0 - initial release
// ============================================================================
interface mult32x32_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  import mult32x32_arb_pkg::*;

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*OP_W-1:0] req_a;
  logic [NUM_REQ*OP_W-1:0] req_b;
  logic [NUM_REQ-1:0]      resp_valid;
  logic [NUM_REQ-1:0]      resp_ready;
  logic [PROD_W-1:0]       resp_product;
  logic [ID_W-1:0]         active_id;
  logic                    mul_start;
  logic [OP_W-1:0]         mul_a;
  logic [OP_W-1:0]         mul_b;
  logic                    mul_busy;
  logic [PROD_W-1:0]       mul_product;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready, mul_busy, mul_product,
    output req_ready, resp_valid, resp_product, active_id,
           mul_start, mul_a, mul_b
  );

  modport master (
    output req_valid, req_a, req_b, resp_ready, mul_busy, mul_product,
    input  req_ready, resp_valid, resp_product, active_id,
           mul_start, mul_a, mul_b
  );

endinterface
`default_nettype wire

// File: rtl/mult32x32_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first asserted
//               request scanning upward from last_grant+1 with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_grant_i,
  output logic               grant_valid_o,
  output logic [ID_W-1:0]    grant_id_o
);

  int w_best;
  int w_dist;

  // Pick the requester with the smallest rotational distance past last_grant
  always_comb begin
    grant_valid_o = 1'b0;
    grant_id_o    = '0;
    w_best        = NUM_REQ;
    w_dist        = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      // distance 0 means requester last_grant+1, NUM_REQ-1 means last_grant
      w_dist = (j - int'(last_grant_i) + 2 * NUM_REQ - 1) % NUM_REQ;
      if (req_i[j] && (w_dist < w_best)) begin
        w_best        = w_dist;
        grant_valid_o = 1'b1;
        grant_id_o    = ID_W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult32x32_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult32x32_arbiter
// Description : Shares one multiplier among NUM_REQ requesters. Accepts an
//               operand pair, pulses start, waits for completion and returns
//               the product to the granted requester. One op in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module mult32x32_arbiter
  import mult32x32_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  mult32x32_arbiter_if.slave  bus
);

  arb_state_t        state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [ID_W-1:0]   active_id_q, active_id_d;
  logic [OP_W-1:0]   op_a_q, op_a_d;
  logic [OP_W-1:0]   op_b_q, op_b_d;
  logic [PROD_W-1:0] result_q, result_d;

  logic              w_grant_valid;
  logic [ID_W-1:0]   w_grant_id;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req_i         (bus.req_valid),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (w_grant_valid),
    .grant_id_o    (w_grant_id)
  );

  // Operands and result feed the multiplier / response bus straight from regs
  assign bus.mul_a        = op_a_q;
  assign bus.mul_b        = op_b_q;
  assign bus.resp_product = result_q;
  assign bus.active_id    = active_id_q;

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      active_id_q  <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      active_id_q  <= active_id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      result_q     <= result_d;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    active_id_d    = active_id_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    result_d       = result_q;
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    bus.mul_start  = 1'b0;

    case (state_q)
      IDLE: begin
        // reset gating keeps req_ready low while reset is held
        if (w_grant_valid && !bus.mul_busy && !reset) begin
          for (int j = 0; j < NUM_REQ; j++) begin
            if (w_grant_id == ID_W'(j)) begin
              bus.req_ready[j] = 1'b1;
              op_a_d           = bus.req_a[j*OP_W +: OP_W];
              op_b_d           = bus.req_b[j*OP_W +: OP_W];
            end
          end
          active_id_d = w_grant_id;
          state_d     = LAUNCH;
        end
      end

      LAUNCH: begin
        bus.mul_start = 1'b1;
        state_d       = WAIT;
      end

      WAIT: begin
        if (!bus.mul_busy) begin
          result_d = bus.mul_product;
          state_d  = RESP;
        end
      end

      RESP: begin
        for (int j = 0; j < NUM_REQ; j++) begin
          if (active_id_q == ID_W'(j)) begin
            bus.resp_valid[j] = 1'b1;
            if (bus.resp_ready[j]) begin
              last_grant_d = active_id_q;
              state_d      = IDLE;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mult32x32_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult32x32_arbiter
// Description : Scoreboard bench for mult32x32_arbiter with a behavioural
//               multiplier and round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult32x32_arbiter;
  import mult32x32_arb_pkg::*;

  localparam int N   = 2;
  localparam int IDW = $clog2(N);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic force_busy = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult32x32_arbiter_if #(.NUM_REQ(N), .ID_W(IDW)) bus ();

  mult32x32_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural multiplier: busy from the cycle after start, 4 or 8 cycles
  logic        m_busy;
  logic [3:0]  m_cnt;
  logic [31:0] m_a, m_b;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_cnt <= 4'd0; m_a <= '0; m_b <= '0;
      bus.mul_product <= '0;
    end else if (!m_busy) begin
      if (bus.mul_start) begin
        m_busy <= 1'b1;
        m_cnt  <= (bus.mul_b[31:16] == 16'd0) ? 4'd4 : 4'd8;
        m_a    <= bus.mul_a;
        m_b    <= bus.mul_b;
      end
    end else begin
      m_cnt <= m_cnt - 4'd1;
      if (m_cnt == 4'd1) begin
        m_busy          <= 1'b0;
        bus.mul_product <= 64'(m_a) * 64'(m_b);
      end
    end
  end
  assign bus.mul_busy = m_busy | force_busy;

  // Scoreboard
  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    int          exp_cyc;
  } txn_t;

  txn_t sbq[$];
  int   grant_log[$];
  int   checks = 0;
  int   failures = 0;
  int   last_grant_m = N - 1;
  int   hs_cyc = -1;
  int   start_cyc = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Request side: reference round-robin grant, expected start, push expectations
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    logic [N-1:0] acc;
    logic         found;
    int           w;
    exp_rdy = '0; found = 1'b0; w = 0;
    if (reset) begin
      start_cyc = -1;
    end else begin
      if (sbq.size() == 0 && cyc > hs_cyc && !bus.mul_busy) begin
        for (int k = 1; k <= N; k++) begin
          if (!found && bus.req_valid[(last_grant_m + k) % N]) begin
            found = 1'b1;
            w     = (last_grant_m + k) % N;
          end
        end
        if (found) exp_rdy[w] = 1'b1;
      end
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      chk("mul_start", 64'(bus.mul_start), 64'(cyc == start_cyc));
      if (cyc == start_cyc && sbq.size() != 0) begin
        chk("mul_a", 64'(bus.mul_a), 64'(sbq[0].a));
        chk("mul_b", 64'(bus.mul_b), 64'(sbq[0].b));
      end
      acc = bus.req_valid & bus.req_ready;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          txn_t t;
          t.id      = i;
          t.a       = bus.req_a[i*32 +: 32];
          t.b       = bus.req_b[i*32 +: 32];
          t.prod    = 64'(t.a) * 64'(t.b);
          t.exp_cyc = cyc + ((t.b[31:16] == 16'd0) ? 7 : 11);
          sbq.push_back(t);
          grant_log.push_back(i);
          start_cyc = cyc + 1;
        end
      end
    end
  end

  // Response monitor: pop and compare whenever a response is due
  always @(negedge clk) begin
    logic [N-1:0] ev;
    ev = '0;
    if (reset) begin
      sbq.delete();
      last_grant_m = N - 1;
      hs_cyc = -1;
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_resp_product", bus.resp_product, 64'd0);
      chk("rst_active_id", 64'(bus.active_id), 64'd0);
      chk("rst_mul_start", 64'(bus.mul_start), 64'd0);
      chk("rst_mul_ab", {bus.mul_a, bus.mul_b}, 64'd0);
    end else if (sbq.size() == 0) begin
      chk("resp_valid_none", 64'(bus.resp_valid), 64'd0);
    end else begin
      if (cyc >= sbq[0].exp_cyc) ev[sbq[0].id] = 1'b1;
      chk("resp_valid", 64'(bus.resp_valid), 64'(ev));
      if (ev != '0) begin
        chk("resp_product", bus.resp_product, sbq[0].prod);
        chk("active_id", 64'(bus.active_id), 64'(sbq[0].id));
        if (bus.resp_ready[sbq[0].id]) begin
          last_grant_m = sbq[0].id;
          hs_cyc = cyc;
          void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic send(input int id, input logic [31:0] a, input logic [31:0] b);
    logic got;
    got = 1'b0;
    bus.req_a[id*32 +: 32] = a;
    bus.req_b[id*32 +: 32] = b;
    bus.req_valid[id] = 1'b1;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      if (bus.req_ready[id]) got = 1'b1;
    end
    chk("send_accept_timeout", 64'(got), 64'd1);
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    logic done;
    done = 1'b0;
    for (int t = 0; t < bound && !done; t++) begin
      @(negedge clk);
      if (sbq.size() == 0 && cyc > hs_cyc) done = 1'b1;
    end
    chk("drain_timeout", 64'(done), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_grant(input logic [N-1:0] exp);
    logic got;
    got = 1'b0;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        got = 1'b1;
        chk("grant_id", 64'(bus.req_ready), 64'(exp));
      end
    end
    chk("grant_timeout", 64'(got), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int          exp_order [4];
    logic [N-1:0] acc;
    int          nacc;
    logic        seen;
    logic [31:0] rb;
    exp_order = '{0, 1, 0, 1};
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Short and long latency directed transactions
    bus.resp_ready = '1;
    send(0, 32'd3, 32'd5);
    wait_idle(100);
    send(1, 32'd2, 32'h0001_0000);
    wait_idle(100);

    // Both requesters valid continuously: grants alternate
    grant_log.delete();
    bus.req_a = {32'd11, 32'd7};
    bus.req_b = {32'h0003_0002, 32'd13};
    bus.req_valid = '1;
    nacc = 0;
    for (int t = 0; t < 200 && nacc < 4; t++) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          nacc++;
          bus.req_a[i*32 +: 32] = $urandom;
          bus.req_b[i*32 +: 32] = $urandom;
        end
      end
      if (nacc >= 4) bus.req_valid = '0;
    end
    bus.req_valid = '0;
    wait_idle(100);
    chk("grant_count", 64'(grant_log.size()), 64'd4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      chk("grant_order", 64'(grant_log[k]), 64'(exp_order[k]));

    // Max operands with a five-cycle response stall; requester 1 waits
    bus.resp_ready = '0;
    send(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bus.req_a[32 +: 32] = 32'd7;
    bus.req_b[32 +: 32] = 32'd9;
    bus.req_valid[1] = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      if (bus.resp_valid[0]) seen = 1'b1;
    end
    chk("stall_resp_seen", 64'(seen), 64'd1);
    for (int t = 0; t < 5; t++) begin
      if (t > 0) @(negedge clk);
      chk("stall_valid", 64'(bus.resp_valid), 64'd1);
      chk("stall_product", bus.resp_product, 64'hFFFF_FFFE_0000_0001);
      chk("stall_no_ready", 64'(bus.req_ready), 64'd0);
    end
    @(posedge clk); #1;
    bus.resp_ready = '1;
    wait_grant(2'b10);
    bus.req_valid = '0;
    wait_idle(100);

    // Reset in WAIT with both requesters valid
    bus.req_a = {32'd5, 32'd6};
    bus.req_b = {32'h0100_0000, 32'h0100_0001};
    bus.req_valid = '1;
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      if (bus.req_ready != '0) seen = 1'b1;
    end
    chk("pre_reset_grant", 64'(seen), 64'd1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_grant(2'b01);
    bus.req_valid = '0;
    wait_idle(100);

    // Multiplier busy in IDLE blocks the grant
    force_busy = 1'b1;
    bus.req_a[0 +: 32] = 32'd21;
    bus.req_b[0 +: 32] = 32'd4;
    bus.req_valid[0] = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk("busy_no_ready", 64'(bus.req_ready), 64'd0);
      chk("busy_no_start", 64'(bus.mul_start), 64'd0);
    end
    @(posedge clk); #1;
    force_busy = 1'b0;
    wait_grant(2'b01);
    bus.req_valid = '0;
    wait_idle(100);

    // Randomized traffic with random response back-pressure
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] || !bus.req_valid[i]) begin
          bus.req_valid[i] = ($urandom_range(0, 2) == 0);
          bus.req_a[i*32 +: 32] = $urandom;
          rb = $urandom;
          if ($urandom_range(0, 1) == 0) rb[31:16] = 16'd0;
          bus.req_b[i*32 +: 32] = rb;
        end
      end
      bus.resp_ready = N'($urandom);
    end
    bus.req_valid = '0;
    bus.resp_ready = '1;
    wait_idle(200);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult32x32_arbiter.md
# mult32x32_arbiter

Round-robin arbiter and sequencer that shares one mult32x32_fast multiplier among NUM_REQ requesters. It accepts operand pairs over valid/ready, launches the multiplier with a one-cycle start pulse, waits for completion and returns the 64-bit product to the granted requester over valid/ready. It sits between client blocks and the multiplier top, and is the only driver of the multiplier's start and operand inputs.

## Interface
- NUM_REQ, default 2: number of requesters, 2..8.
- ID_W, default $clog2(NUM_REQ): width of the requester index.

- clk  input  1  clock
- reset  input  1  asynchronous, active-high
- req_valid  input  NUM_REQ  per-requester operand valid
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
- req_a  input  NUM_REQ*32  operand A, requester i at bits [32i+31:32i]
- req_b  input  NUM_REQ*32  operand B, same packing
- resp_valid  output  NUM_REQ  product valid for requester i; one-hot or zero
- resp_ready  input  NUM_REQ  per-requester response accept
- resp_product  output  64  product, shared by all requesters
- active_id  output  ID_W  index of the requester currently owning the multiplier
- mul_start  output  1  start pulse to the multiplier
- mul_a, mul_b  output  32 each  operands to the multiplier
- mul_busy  input  1  multiplier busy
- mul_product  input  64  multiplier product

## Operation
- FSM states are IDLE, LAUNCH, WAIT and RESP.
- **IDLE**
  - Grant only when some req_valid bit is high and mul_busy=0.
  - The winner is the first valid requester scanning upward from last_grant+1, with modulo NUM_REQ wrap.
  - req_ready[winner] is driven combinationally in the same cycle.
  - On that edge: req_a/req_b slices are captured into op_a/op_b, active_id takes the winner, and the FSM moves to LAUNCH.
- **LAUNCH**
  - mul_start=1 for exactly one cycle, then WAIT.
- **WAIT**
  - When mul_busy=0, capture mul_product into the result register and move to RESP.
  - mul_busy is high in the first WAIT cycle because the multiplier has already left its idle state.
- **RESP**
  - resp_valid[active_id]=1 until resp_ready[active_id]=1.
  - On the handshake edge: last_grant takes active_id and the FSM returns to IDLE.
- mul_a/mul_b are driven from op_a/op_b at all times, so they are stable for the whole operation.
- resp_product is driven from the result register at all times; it is meaningful only while resp_valid is set.
- No new grant is issued while in LAUNCH, WAIT or RESP, so there is exactly one outstanding operation.
- No arithmetic is done in this block; the product is passed through unmodified at 64 bits.

## Timing
- Reset values:
  - state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first).
  - op_a, op_b, result and active_id are 0.
  - All outputs are 0.
- Latency, counting the accept cycle as cycle 0:
  - LAUNCH is cycle 1; the multiplier is busy from cycle 2.
  - Operand B upper 16 bits zero: 4 busy cycles, capture in cycle 6, resp_valid from cycle 7.
  - Otherwise: 8 busy cycles, capture in cycle 10, resp_valid from cycle 11.
- Back-to-back operation: the earliest next grant is the cycle after the RESP handshake.
- Simultaneous valid requests: only the round-robin winner sees req_ready; the others hold their valid.
- resp_ready low stalls RESP indefinitely. resp_valid and resp_product stay stable, and no new grant is made.
- resp_ready on a non-active index is ignored.
- req_valid dropping after accept has no effect.
- Reset asserted mid-operation (any state) returns everything to reset values immediately.
  - The in-flight operation is discarded with no response.
  - The multiplier is reset by the same signal.

## Structure
- Package mult32x32_arb_pkg holds:
  - the arb_state_t enum {IDLE, LAUNCH, WAIT, RESP};
  - localparams OP_W=32 and PROD_W=64.
- Sub-module rr_pick (combinational) takes req, last_grant and NUM_REQ, and returns grant_valid and grant_id.
- The top instantiates rr_pick and contains the FSM and registers.

## Test plan
- After reset, requester 0 sends a=3, b=5 and resp_ready is held high.
  - mul_start pulses exactly once, in cycle 1.
  - resp_valid[0] in cycle 7 with resp_product=15.
- Requester 1 sends a=2, b=0x0001_0000.
  - resp_valid[1] in cycle 11 with resp_product=0x0000_0000_0002_0000.
- Both requesters valid continuously from reset with different operands.
  - Grants alternate 0,1,0,1.
  - Each product is correct and returned only on its own resp_valid bit.
- a=0xFFFF_FFFF, b=0xFFFF_FFFF with resp_ready held low for 5 cycles, then high.
  - resp_valid and resp_product stay at 0xFFFF_FFFE_0000_0001 throughout the stall.
  - No req_ready is asserted during the stall; IDLE is re-entered after the handshake.
- Reset pulsed in WAIT cycle 3 while both requesters are valid.
  - All outputs are 0 during reset and no response is issued for the dropped operation.
  - Requester 0 is granted first after release.
- mul_busy forced high in IDLE with req_valid[0]=1 (model check).
  - No req_ready and no mul_start until mul_busy drops.
